// File: rtl/shaft_pulse_monitor_if.sv
// ---------------------------------------------------------------------------
// shaft_pulse_monitor_if
//   Signal bundle between the drive controller and the wheel-feedback
//   receiver.
//
//   Controller -> receiver : shaftPulseL, shaftPulseR (raw encoder pulses),
//                            driveActive (motor enables on),
//                            clearDist (clear both distance counters)
//   Receiver -> controller : speedL, speedR, speedDiff, speedValid,
//                            distL, distR, stallL, stallR
//
//   modport master : drive-controller side (also used by test stimulus)
//   modport slave  : shaft_pulse_monitor side
// ---------------------------------------------------------------------------
interface shaft_pulse_monitor_if #(
  parameter int SPEED_WIDTH = 16,
  parameter int DIST_WIDTH  = 24
);
  logic                   shaftPulseL;
  logic                   shaftPulseR;
  logic                   driveActive;
  logic                   clearDist;
  logic [SPEED_WIDTH-1:0] speedL;
  logic [SPEED_WIDTH-1:0] speedR;
  logic [SPEED_WIDTH:0]   speedDiff;
  logic                   speedValid;
  logic [DIST_WIDTH-1:0]  distL;
  logic [DIST_WIDTH-1:0]  distR;
  logic                   stallL;
  logic                   stallR;

  modport master (
    output shaftPulseL, shaftPulseR, driveActive, clearDist,
    input  speedL, speedR, speedDiff, speedValid, distL, distR, stallL, stallR
  );

  modport slave (
    input  shaftPulseL, shaftPulseR, driveActive, clearDist,
    output speedL, speedR, speedDiff, speedValid, distL, distR, stallL, stallR
  );
endinterface

// File: rtl/shaft_pulse_monitor.sv
// ---------------------------------------------------------------------------
// shaft_pulse_monitor
//   Wheel-feedback receiver. Each raw encoder pulse is synchronized, debounced
//   and turned into a one-cycle rising-edge pulse. Edges are counted per
//   measurement window (speed), cumulatively (distance), and watched by a
//   per-wheel stall state machine while the drive is active.
//
//   Ports:
//     clk    : system clock
//     resetN : synchronous active-low reset
//     bus    : shaft_pulse_monitor_if.slave
//              in : shaftPulseL/R, driveActive, clearDist
//              out: speedL/R, speedDiff, speedValid, distL/R, stallL/R
//
//   Index 0 of every per-wheel array is the left wheel, index 1 the right.
// ---------------------------------------------------------------------------
module shaft_pulse_monitor #(
  parameter int WINDOW_CYCLES   = 5_000_000,
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int STALL_WINDOWS   = 3,
  parameter int SPEED_WIDTH     = 16,
  parameter int DIST_WIDTH      = 24
) (
  input  logic                 clk,
  input  logic                 resetN,
  shaft_pulse_monitor_if.slave bus
);

  localparam int WIN_W = (WINDOW_CYCLES > 1)   ? $clog2(WINDOW_CYCLES)   : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ZW    = $clog2(STALL_WINDOWS + 1);

  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] DEB_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [ZW-1:0] Z_ZERO  = {ZW{1'b0}};
  localparam logic [ZW-1:0] Z_ONE   = {{(ZW-1){1'b0}}, 1'b1};
  localparam logic [ZW-1:0] Z_LIMIT = ZW'(STALL_WINDOWS);

  localparam logic [SPEED_WIDTH-1:0] SPEED_ZERO = {SPEED_WIDTH{1'b0}};
  localparam logic [SPEED_WIDTH-1:0] SPEED_ONE  = {{(SPEED_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SPEED_WIDTH-1:0] SPEED_MAX  = {SPEED_WIDTH{1'b1}};

  localparam logic [DIST_WIDTH-1:0] DIST_ZERO = {DIST_WIDTH{1'b0}};
  localparam logic [DIST_WIDTH-1:0] DIST_ONE  = {{(DIST_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIST_WIDTH-1:0] DIST_MAX  = {DIST_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WATCH   = 2'd1,
    ST_STALLED = 2'd2
  } stall_state_t;

  // Saturating increment for per-window edge counters.
  function automatic logic [SPEED_WIDTH-1:0] sat_inc_speed(
    input logic [SPEED_WIDTH-1:0] value,
    input logic                   inc
  );
    if (inc && (value != SPEED_MAX)) begin
      sat_inc_speed = value + SPEED_ONE;
    end else begin
      sat_inc_speed = value;
    end
  endfunction

  // Saturating increment for the cumulative distance counters.
  function automatic logic [DIST_WIDTH-1:0] sat_inc_dist(
    input logic [DIST_WIDTH-1:0] value,
    input logic                  inc
  );
    if (inc && (value != DIST_MAX)) begin
      sat_inc_dist = value + DIST_ONE;
    end else begin
      sat_inc_dist = value;
    end
  endfunction

  logic [1:0]             raw_s;
  logic [1:0]             sync1_r;
  logic [1:0]             sync2_r;
  logic [1:0]             filt_r;
  logic [1:0]             filt_d_r;
  logic [1:0]             edge_r;
  logic [DEB_W-1:0]       deb_cnt_r [2];

  logic [WIN_W-1:0]       win_r;
  logic                   terminal_s;
  logic [SPEED_WIDTH-1:0] run_r   [2];
  logic [SPEED_WIDTH-1:0] close_s [2];
  logic [SPEED_WIDTH-1:0] speed_r [2];
  logic [SPEED_WIDTH:0]   diff_r;
  logic                   valid_r;

  logic [DIST_WIDTH-1:0]  dist_l_r;
  logic [DIST_WIDTH-1:0]  dist_r_r;

  stall_state_t           state_r [2];
  stall_state_t           state_s [2];
  logic [ZW-1:0]          zero_r  [2];
  logic [ZW-1:0]          zero_s  [2];
  logic [1:0]             stall_r;

  assign raw_s = {bus.shaftPulseR, bus.shaftPulseL};

  // Synchronizer, debounce filter and registered rising-edge pulse per wheel.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      sync1_r  <= 2'b00;
      sync2_r  <= 2'b00;
      filt_r   <= 2'b00;
      filt_d_r <= 2'b00;
      edge_r   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_r[i] <= DEB_ZERO;
      end
    end else begin
      sync1_r  <= raw_s;
      sync2_r  <= sync1_r;
      filt_d_r <= filt_r;
      edge_r   <= filt_r & ~filt_d_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == filt_r[i]) begin
          deb_cnt_r[i] <= DEB_ZERO;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          // The synchronized level has now disagreed for DEBOUNCE_CYCLES samples.
          filt_r[i]    <= sync2_r[i];
          deb_cnt_r[i] <= DEB_ZERO;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
        end
      end
    end
  end

  assign terminal_s = (win_r == WIN_LAST);

  // Closing count of the current window, including an edge on this very cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      close_s[i] = sat_inc_speed(run_r[i], edge_r[i]);
    end
  end

  // Window timer, running edge counters and the published speed snapshot.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      win_r   <= WIN_ZERO;
      diff_r  <= {(SPEED_WIDTH+1){1'b0}};
      valid_r <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        run_r[i]   <= SPEED_ZERO;
        speed_r[i] <= SPEED_ZERO;
      end
    end else begin
      valid_r <= terminal_s;
      if (terminal_s) begin
        win_r  <= WIN_ZERO;
        diff_r <= {1'b0, close_s[0]} - {1'b0, close_s[1]};
        for (int i = 0; i < 2; i++) begin
          // The terminal-cycle edge was folded into close_s, so the next
          // window starts from zero.
          speed_r[i] <= close_s[i];
          run_r[i]   <= SPEED_ZERO;
        end
      end else begin
        win_r <= win_r + WIN_ONE;
        for (int i = 0; i < 2; i++) begin
          run_r[i] <= close_s[i];
        end
      end
    end
  end

  // Cumulative distance; a clear takes priority over a simultaneous edge.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      dist_l_r <= DIST_ZERO;
      dist_r_r <= DIST_ZERO;
    end else if (bus.clearDist) begin
      dist_l_r <= DIST_ZERO;
      dist_r_r <= DIST_ZERO;
    end else begin
      dist_l_r <= sat_inc_dist(dist_l_r, edge_r[0]);
      dist_r_r <= sat_inc_dist(dist_r_r, edge_r[1]);
    end
  end

  // Stall state machines: state register and registered stall outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      stall_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        state_r[i] <= ST_IDLE;
        zero_r[i]  <= Z_ZERO;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_r[i] <= state_s[i];
        zero_r[i]  <= zero_s[i];
        stall_r[i] <= (state_s[i] == ST_STALLED);
      end
    end
  end

  // Stall state machines: next state and zero-window count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_s[i] = state_r[i];
      zero_s[i]  = zero_r[i];
      if (!bus.driveActive) begin
        // Dropping the motor enables overrides everything, terminal or not.
        state_s[i] = ST_IDLE;
        zero_s[i]  = Z_ZERO;
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            state_s[i] = ST_WATCH;
            zero_s[i]  = Z_ZERO;
          end
          ST_WATCH: begin
            if (terminal_s) begin
              if (close_s[i] == SPEED_ZERO) begin
                zero_s[i] = zero_r[i] + Z_ONE;
                if ((zero_r[i] + Z_ONE) == Z_LIMIT) begin
                  state_s[i] = ST_STALLED;
                end else begin
                  state_s[i] = ST_WATCH;
                end
              end else begin
                zero_s[i] = Z_ZERO;
              end
            end else begin
              state_s[i] = ST_WATCH;
            end
          end
          ST_STALLED: begin
            if (terminal_s && (close_s[i] != SPEED_ZERO)) begin
              state_s[i] = ST_WATCH;
              zero_s[i]  = Z_ZERO;
            end else begin
              state_s[i] = ST_STALLED;
            end
          end
          default: begin
            state_s[i] = ST_IDLE;
            zero_s[i]  = Z_ZERO;
          end
        endcase
      end
    end
  end

  assign bus.speedL     = speed_r[0];
  assign bus.speedR     = speed_r[1];
  assign bus.speedDiff  = diff_r;
  assign bus.speedValid = valid_r;
  assign bus.distL      = dist_l_r;
  assign bus.distR      = dist_r_r;
  assign bus.stallL     = stall_r[0];
  assign bus.stallR     = stall_r[1];

endmodule

// File: tb/tb_shaft_pulse_monitor.sv
// ---------------------------------------------------------------------------
// tb_shaft_pulse_monitor
//   Bench for shaft_pulse_monitor. Each phase builds per-cycle raw pulse
//   waveforms for both wheels, derives the expected per-window results from
//   the waveform (a rise counts when its high run lasts DEBOUNCE_CYCLES or
//   more and shows up as an edge DEBOUNCE_CYCLES+3 cycles later), queues them,
//   and then plays the waveform. An independent monitor compares whenever
//   speedValid is seen.
// ---------------------------------------------------------------------------
module tb_shaft_pulse_monitor;

  localparam int W    = 1000;
  localparam int D    = 4;
  localparam int S    = 3;
  localparam int SW   = 16;
  localparam int DW   = 24;
  localparam int MAXW = 4;

  typedef struct {
    int sl;
    int sr;
    int dl;
    int dr;
    bit stl;
    bit str;
  } exp_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc;
  bit   sb_on = 1'b0;
  exp_t q[$];
  bit   wl [0:MAXW*W-1];
  bit   wr [0:MAXW*W-1];
  int   mode_l [MAXW];
  int   mode_r [MAXW];

  shaft_pulse_monitor_if #(.SPEED_WIDTH(SW), .DIST_WIDTH(DW)) bus ();

  shaft_pulse_monitor #(
    .WINDOW_CYCLES(W), .DEBOUNCE_CYCLES(D), .STALL_WINDOWS(S),
    .SPEED_WIDTH(SW), .DIST_WIDTH(DW)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (!resetN) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic void chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb_on && resetN && bus.speedValid) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("window_period", cyc % W, 0);
        chk("speedL", bus.speedL, e.sl);
        chk("speedR", bus.speedR, e.sr);
        chk("speedDiff", $signed(bus.speedDiff), e.sl - e.sr);
        chk("distL", bus.distL, e.dl);
        chk("distR", bus.distR, e.dr);
        chk("stallL", bus.stallL, e.stl);
        chk("stallR", bus.stallR, e.str);
      end
    end
  end

  function automatic void put(bit is_r, int idx, bit v);
    if (is_r) wr[idx] = v;
    else      wl[idx] = v;
  endfunction

  function automatic bit get(bit is_r, int idx);
    return is_r ? wr[idx] : wl[idx];
  endfunction

  // Waveform for one window of one wheel.
  function automatic void fill_side(bit is_r, int w, int mode);
    int base = w * W;
    int t;
    int lo;
    int hi;
    for (int i = 0; i < W; i++) put(is_r, base + i, 1'b0);
    case (mode)
      1: for (int i = 0; i < W; i++) put(is_r, base + i, (i % 100) < 50);
      2: for (int i = 0; i < W; i++) put(is_r, base + i, (i % 200) < 100);
      3: for (int i = 0; i < W; i++) put(is_r, base + i, (i % 50) < 3);
      4: for (int i = 0; i < W; i++) put(is_r, base + i, (i % 50) < 5);
      5: begin
        t = 0;
        while (1) begin
          lo = $urandom_range(60, 4);
          t += lo;
          if ($urandom_range(2, 0) == 0) hi = $urandom_range(3, 1);
          else                           hi = $urandom_range(60, 4);
          if (t + hi > W - 20) break;
          for (int i = 0; i < hi; i++) put(is_r, base + t + i, 1'b1);
          t += hi;
        end
      end
      6: for (int i = 992; i < 998; i++) put(is_r, base + i, 1'b1);
      7: for (int i = 993; i < 999; i++) put(is_r, base + i, 1'b1);
      default: ;
    endcase
  endfunction

  // Edges attributed to window w: qualifying rises whose edge lands in it.
  function automatic int edges_in(bit is_r, int nwin, int w);
    int n = 0;
    int h;
    for (int m = 0; m < nwin * W; m++) begin
      if (get(is_r, m) && (m == 0 || !get(is_r, m - 1))) begin
        h = 0;
        while (m + h < nwin * W && get(is_r, m + h)) h++;
        if (h >= D && (m + D + 3) / W == w) n++;
      end
    end
    return n;
  endfunction

  task automatic set_modes(int w, int ml, int mr);
    mode_l[w] = ml;
    mode_r[w] = mr;
  endtask

  task automatic do_reset(bit drive);
    bus.shaftPulseL = 1'b0;
    bus.shaftPulseR = 1'b0;
    bus.clearDist   = 1'b0;
    bus.driveActive = drive;
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  task automatic check_zero();
    chk("rst_speedL", bus.speedL, 0);
    chk("rst_speedR", bus.speedR, 0);
    chk("rst_speedDiff", bus.speedDiff, 0);
    chk("rst_speedValid", bus.speedValid, 0);
    chk("rst_distL", bus.distL, 0);
    chk("rst_distR", bus.distR, 0);
    chk("rst_stallL", bus.stallL, 0);
    chk("rst_stallR", bus.stallR, 0);
  endtask

  // Must be called right after reset release; plays nwin windows.
  task automatic run_phase(int nwin, bit drive);
    exp_t e;
    int el, er;
    int dl = 0, dr = 0, zl = 0, zr = 0;
    for (int w = 0; w < nwin; w++) begin
      fill_side(1'b0, w, mode_l[w]);
      fill_side(1'b1, w, mode_r[w]);
    end
    for (int w = 0; w < nwin; w++) begin
      el = edges_in(1'b0, nwin, w);
      er = edges_in(1'b1, nwin, w);
      dl += el;
      dr += er;
      zl = (el == 0) ? zl + 1 : 0;
      zr = (er == 0) ? zr + 1 : 0;
      e.sl = el; e.sr = er; e.dl = dl; e.dr = dr;
      e.stl = drive && (zl >= S);
      e.str = drive && (zr >= S);
      q.push_back(e);
    end
    sb_on = 1'b1;
    for (int m = 0; m < nwin * W; m++) begin
      bus.shaftPulseL = wl[m];
      bus.shaftPulseR = wr[m];
      @(posedge clk);
      #1;
    end
    bus.shaftPulseL = 1'b0;
    bus.shaftPulseR = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", q.size(), 0);
    q.delete();
    sb_on = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw-to-edge latency seen through distL, then clear against an edge.
  task automatic latency_and_clear();
    bus.shaftPulseL = 1'b1;   // rise driven at cycle 0
    step(5);
    bus.shaftPulseL = 1'b0;
    step(2);                  // cyc 7: edge pulse visible, not yet counted
    chk("edge_latency_early", bus.distL, 0);
    step(1);                  // cyc 8
    chk("edge_latency_7clk", bus.distL, 1);
    step(12);                 // cyc 20
    bus.shaftPulseL = 1'b1;
    step(5);
    bus.shaftPulseL = 1'b0;
    step(2);                  // cyc 27: second edge is being counted next
    chk("dist_before_clear", bus.distL, 1);
    bus.clearDist = 1'b1;
    step(1);
    bus.clearDist = 1'b0;
    chk("clear_beats_edge", bus.distL, 0);
    step(10);
    chk("edge_dropped_after_clear", bus.distL, 0);
  endtask

  task automatic saturation();
    force dut.dist_l_r = 24'hFFFFFC;
    step(1);
    release dut.dist_l_r;
    for (int p = 0; p < 5; p++) begin
      bus.shaftPulseL = 1'b1;
      step(5);
      bus.shaftPulseL = 1'b0;
      step(10);
    end
    step(10);
    chk("distL_saturates", bus.distL, 24'hFFFFFF);
    chk("distR_untouched", bus.distR, 0);
    // Leave a partial window of counts in flight before the reset.
    bus.shaftPulseR = 1'b1;
    step(6);
    bus.shaftPulseR = 1'b0;
    step(20);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    bit d;
    bus.shaftPulseL = 1'b0;
    bus.shaftPulseR = 1'b0;
    bus.driveActive = 1'b0;
    bus.clearDist   = 1'b0;

    // Reset then idle
    do_reset(1'b0);
    check_zero();
    for (int w = 0; w < 2; w++) set_modes(w, 0, 0);
    run_phase(2, 1'b0);

    // Square waves, left period 100, right period 200
    do_reset(1'b1);
    for (int w = 0; w < 3; w++) set_modes(w, 1, 2);
    run_phase(3, 1'b1);

    // 3-cycle glitches, then 5-cycle pulses
    do_reset(1'b0);
    for (int w = 0; w < 2; w++) set_modes(w, 3, 0);
    run_phase(2, 1'b0);
    do_reset(1'b0);
    for (int w = 0; w < 2; w++) set_modes(w, 4, 0);
    run_phase(2, 1'b0);

    // Latency and clear priority
    do_reset(1'b0);
    latency_and_clear();

    // Right stall, then resume
    do_reset(1'b1);
    for (int w = 0; w < 4; w++) set_modes(w, 5, 0);
    set_modes(3, 5, 1);
    run_phase(4, 1'b1);

    // Right stall, then drive dropped mid-stall
    do_reset(1'b1);
    for (int w = 0; w < 4; w++) set_modes(w, 5, 0);
    run_phase(4, 1'b1);
    chk("stallR_held", bus.stallR, 1);
    bus.driveActive = 1'b0;
    step(1);
    chk("stallR_drop_on_drive_low", bus.stallR, 0);
    chk("stallL_drop_on_drive_low", bus.stallL, 0);

    // Edges on and just after the terminal cycle
    do_reset(1'b0);
    set_modes(0, 6, 7);
    set_modes(1, 0, 0);
    run_phase(2, 1'b0);

    // Distance saturation, reset mid-window, clean restart
    do_reset(1'b0);
    saturation();
    do_reset(1'b0);
    check_zero();
    for (int w = 0; w < 2; w++) set_modes(w, 5, 5);
    run_phase(2, 1'b0);

    // Randomized traffic
    for (int r = 0; r < 3; r++) begin
      d = 1'($urandom_range(1, 0));
      do_reset(d);
      for (int w = 0; w < 3; w++) set_modes(w, 5, 5);
      run_phase(3, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
